// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: one-deep pipeline register with a skid entry for
// valid/ready flow control. in_ready depends only on registered state and
// flush, so upstream never sees a combinational path from out_ready. A
// synchronous flush discards held beats and counts them in a saturating
// drop counter. Keep bits of the payload survive flush by tracking in_data.
module pipe_stage_skid #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] KEEP_MASK = '0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             skid_full,
    output logic [CNT_W-1:0] drop_cnt
);

    logic             main_v;
    logic             skid_v;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_d;
    logic [CNT_W-1:0] drop_q;
    logic             accept;
    logic             send;
    logic [1:0]       drop_inc;

    // Add a small increment to the drop counter, clamping at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        if (sum[CNT_W]) begin
            return '1;
        end
        return sum[CNT_W-1:0];
    endfunction

    // The skid entry is the only thing that can throttle upstream.
    assign in_ready  = ~skid_v & ~flush;
    assign accept    = in_valid & in_ready;
    assign send      = main_v & out_ready;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign skid_full = skid_v;
    assign drop_cnt  = drop_q;

    // Beats lost to a flush: a main beat not leaving this cycle plus any skid beat.
    assign drop_inc = {1'b0, main_v & ~out_ready} + {1'b0, skid_v};

    // Occupancy flags; skid only fills when main is held, so skid_v implies main_v.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (send) begin
            if (skid_v) begin
                main_v <= 1'b1;
                skid_v <= 1'b0;
            end else begin
                main_v <= accept;
            end
        end else if (accept) begin
            if (!main_v) begin
                main_v <= 1'b1;
            end else begin
                skid_v <= 1'b1;
            end
        end
    end

    // Payload movement mirrors the occupancy updates; flush leaves only keep bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_d <= '0;
            skid_d <= '0;
        end else if (flush) begin
            main_d <= in_data & KEEP_MASK;
        end else if (send) begin
            if (skid_v) begin
                main_d <= skid_d;
            end else if (accept) begin
                main_d <= in_data;
            end
        end else if (accept) begin
            if (!main_v) begin
                main_d <= in_data;
            end else begin
                skid_d <= in_data;
            end
        end
    end

    // Saturating tally of beats discarded by flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_q <= '0;
        end else if (flush) begin
            drop_q <= sat_add(drop_q, drop_inc);
        end
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter KEEP_MASK, WIDTH bits, default all-zero; set bits are "keep" fields that are not zeroed by flush.
REQ-003 SHALL have parameter CNT_W, default 8, width of the drop counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous flush request.
REQ-007 SHALL have port in_valid  input  1  upstream beat valid.
REQ-008 SHALL have port in_ready  output  1  stage can accept a beat.
REQ-009 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-010 SHALL have port out_valid  output  1  main register holds a valid beat.
REQ-011 SHALL have port out_ready  input  1  downstream accepts a beat.
REQ-012 SHALL have port out_data  output  WIDTH  main register payload.
REQ-013 SHALL have port skid_full  output  1  skid register occupied.
REQ-014 SHALL have port drop_cnt  output  CNT_W  saturating count of beats discarded by flush.

Function
REQ-015 SHALL hold one main entry (main_v, main_d) and one skid entry (skid_v, skid_d).
REQ-016 SHALL drive out_valid=main_v, out_data=main_d, skid_full=skid_v.
REQ-017 SHALL drive in_ready = ~skid_v & ~flush; the only combinational input-to-output path is flush->in_ready.
REQ-018 SHALL define accept = in_valid & in_ready and send = main_v & out_ready.
REQ-019 SHALL load an accepted beat into main when ~main_v or send; otherwise into skid (skid_v<=1).
REQ-020 SHALL move skid into main on send when skid_v=1; that same cycle the new input cannot be accepted (in_ready=0), so ordering is preserved.
REQ-021 SHALL clear main_v on send when neither skid nor accept provides a replacement.
REQ-022 SHALL hold main and skid unchanged when ~send and ~accept.
REQ-023 SHALL give latency of exactly one cycle from accept to out_valid when the stage is empty.
REQ-024 SHALL sustain one beat per cycle when out_ready is held high.
REQ-025 SHALL, on flush=1 (highest priority), set main_v<=0, skid_v<=0, and main_d<=in_data & KEEP_MASK; non-keep bits become 0 and keep bits track in_data, matching the special-field behaviour of existing stage registers.
REQ-026 SHALL complete an output handshake (send) occurring in a flush cycle normally; that beat is not counted as dropped.
REQ-027 SHALL, on flush, add (main_v & ~out_ready) + skid_v (0..2) to drop_cnt.
REQ-028 SHALL saturate drop_cnt at 2^CNT_W-1 and never wrap.
REQ-029 SHALL ignore in_valid during flush (in_ready=0), so no beat is accepted and none is counted as dropped.
REQ-030 SHALL never hold skid_v=1 while main_v=0.

Reset
REQ-031 SHALL, while reset=0, asynchronously force main_v=0, skid_v=0, main_d=0, skid_d=0, drop_cnt=0; resulting outputs are out_valid=0, out_data=0, skid_full=0, in_ready=1 (if flush=0).
REQ-032 SHALL abort any in-flight beats on reset mid-operation without incrementing drop_cnt, and resume normal operation on the first rising edge after reset=1.

Verification
REQ-033 SHALL be verified by: reset, then in_valid=1 with in_data=0x11,0x22,0x33 and out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, each one cycle after its accept; skid_full stays 0.
REQ-034 SHALL be verified by: main holds 0xA, out_ready=0, in_valid=1 with 0xB -> skid_full=1, in_ready=0; raise out_ready -> outputs 0xA then 0xB, no loss or reorder.
REQ-035 SHALL be verified by: KEEP_MASK=0xFFFF0000, main and skid full, out_ready=0, flush=1 with in_data=0x12345678 -> next cycle out_valid=0, out_data=0x12340000, skid_full=0, drop_cnt=2.
REQ-036 SHALL be verified by: flush with main_v=1 and out_ready=1 -> beat delivered, drop_cnt unchanged; with CNT_W=2, 3 drops + 2 drops -> drop_cnt=3 (saturated).
REQ-037 SHALL be verified by: reset asserted asynchronously between clock edges with both entries full -> outputs clear immediately, drop_cnt=0, in_ready=1.
REQ-038 SHALL be verified by: random in_valid/out_ready/flush stimulus against a reference queue model -> data order is preserved, every beat is either delivered or counted exactly once, and skid_v=1 never occurs while main_v=0.
